// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one cache port between instruction fetch (I) and the memory stage (D)
//
// Ports:
//   i_clk, i_rst_n                  clock (rising edge), asynchronous active-low reset
//   i_if_req/i_if_addr/i_if_flush   fetch request (level until done), address, fetch kill
//   o_if_rdata/o_if_done            fetch read data, one-cycle fetch completion pulse
//   i_dm_req/i_dm_wr_en/i_dm_addr   data request (level until done), store flag, address
//   i_dm_wdata/i_dm_datasize        store data, access size code
//   o_dm_rdata/o_dm_done            load data, one-cycle data completion pulse
//   o_port_req/o_port_wr_en         cache request (held while busy), cache write enable
//   o_port_addr/o_port_wdata        cache address, cache write data
//   o_port_datasize                 cache access size code
//   i_port_rdata/i_port_done        cache read data, cache completion pulse
//   o_arb_err                       one-cycle pulse when the watchdog aborts a transaction
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int SIZE_W = 6,
    parameter int TIMEOUT = 256,
    parameter logic [SIZE_W-1:0] DATA_64 = SIZE_W'(3)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_if_flush,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_done,
    input  logic              i_dm_req,
    input  logic              i_dm_wr_en,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    input  logic [SIZE_W-1:0] i_dm_datasize,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_dm_done,
    output logic              o_port_req,
    output logic              o_port_wr_en,
    output logic [ADDR_W-1:0] o_port_addr,
    output logic [DATA_W-1:0] o_port_wdata,
    output logic [SIZE_W-1:0] o_port_datasize,
    input  logic [DATA_W-1:0] i_port_rdata,
    input  logic              i_port_done,
    output logic              o_arb_err
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]        r_state;
    logic              r_last_d;
    logic              r_kill;
    logic [WD_W-1:0]   r_wd_cnt;
    logic              r_port_req;
    logic              r_port_wr_en;
    logic [ADDR_W-1:0] r_port_addr;
    logic [DATA_W-1:0] r_port_wdata;
    logic [SIZE_W-1:0] r_port_datasize;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_if_done;
    logic              r_dm_done;
    logic              r_arb_err;

    logic w_elig_i;
    logic w_elig_d;
    logic w_grant;
    logic w_grant_d;
    logic w_timeout;
    logic w_kill;

    assign w_elig_i  = i_if_req & ~i_if_flush;
    assign w_elig_d  = i_dm_req;
    assign w_grant   = w_elig_i | w_elig_d;
    // on a tie the requester that did not go last wins
    assign w_grant_d = w_elig_d & (~w_elig_i | ~r_last_d);
    assign w_timeout = (TIMEOUT != 0) && (r_wd_cnt == WD_W'(TIMEOUT - 1));
    // a flush arriving in the very cycle the cache completes still kills the fetch
    assign w_kill    = r_kill | i_if_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= IDLE;
            r_last_d        <= 1'b0;
            r_kill          <= 1'b0;
            r_wd_cnt        <= '0;
            r_port_req      <= 1'b0;
            r_port_wr_en    <= 1'b0;
            r_port_addr     <= '0;
            r_port_wdata    <= '0;
            r_port_datasize <= '0;
            r_if_rdata      <= '0;
            r_dm_rdata      <= '0;
            r_if_done       <= 1'b0;
            r_dm_done       <= 1'b0;
            r_arb_err       <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_dm_done <= 1'b0;
            r_arb_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state         <= w_grant_d ? BUSY_D : BUSY_I;
                        r_last_d        <= w_grant_d;
                        r_wd_cnt        <= '0;
                        r_port_req      <= 1'b1;
                        r_port_wr_en    <= w_grant_d & i_dm_wr_en;
                        r_port_addr     <= w_grant_d ? i_dm_addr : i_if_addr;
                        r_port_wdata    <= w_grant_d ? i_dm_wdata : '0;
                        r_port_datasize <= w_grant_d ? i_dm_datasize : DATA_64;
                    end
                end
                BUSY_I, BUSY_D: begin
                    r_wd_cnt <= r_wd_cnt + 1'b1;
                    if (r_state == BUSY_I && i_if_flush)
                        r_kill <= 1'b1;
                    // completion wins over a watchdog expiry in the same cycle
                    if (i_port_done || w_timeout) begin
                        r_state    <= RESP;
                        r_port_req <= 1'b0;
                        r_arb_err  <= ~i_port_done;
                        if (r_state == BUSY_D) begin
                            r_dm_done <= 1'b1;
                            if (!i_port_done)
                                r_dm_rdata <= '0;
                            else if (!r_port_wr_en)
                                r_dm_rdata <= i_port_rdata;
                        end else if (!w_kill) begin
                            r_if_done  <= 1'b1;
                            r_if_rdata <= i_port_done ? i_port_rdata : '0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_kill  <= 1'b0;
                end
            endcase
        end
    end

    assign o_if_rdata      = r_if_rdata;
    assign o_if_done       = r_if_done;
    assign o_dm_rdata      = r_dm_rdata;
    assign o_dm_done       = r_dm_done;
    assign o_port_req      = r_port_req;
    assign o_port_wr_en    = r_port_wr_en;
    assign o_port_addr     = r_port_addr;
    assign o_port_wdata    = r_port_wdata;
    assign o_port_datasize = r_port_datasize;
    assign o_arb_err       = r_arb_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a cache responder model
module tb_mem_port_arbiter;
    localparam int TO = 8;
    localparam int NO_RESP = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0, if_done;
    logic [63:0] if_addr = '0, if_rdata;
    logic        dm_req = 1'b0, dm_wr_en = 1'b0, dm_done;
    logic [63:0] dm_addr = '0, dm_wdata = '0, dm_rdata;
    logic [5:0]  dm_size = '0;
    logic        port_req, port_wr_en, arb_err;
    logic [63:0] port_addr, port_wdata;
    logic [5:0]  port_size;
    logic [63:0] port_rdata = '0;
    logic        port_done = 1'b0;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
        .o_if_rdata(if_rdata), .o_if_done(if_done),
        .i_dm_req(dm_req), .i_dm_wr_en(dm_wr_en), .i_dm_addr(dm_addr),
        .i_dm_wdata(dm_wdata), .i_dm_datasize(dm_size),
        .o_dm_rdata(dm_rdata), .o_dm_done(dm_done),
        .o_port_req(port_req), .o_port_wr_en(port_wr_en), .o_port_addr(port_addr),
        .o_port_wdata(port_wdata), .o_port_datasize(port_size),
        .i_port_rdata(port_rdata), .i_port_done(port_done), .o_arb_err(arb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit d; bit wr; logic [63:0] addr; logic [63:0] wdata; logic [5:0] size;
        logic [63:0] prdata; int delay; bit kill;
    } txn_t;
    typedef struct { bit d; logic [63:0] rdata; bit err; } exp_t;

    txn_t port_q[$];
    exp_t done_q[$];
    int total = 0, bad = 0;
    bit resp_en = 1'b1;
    bit last_d = 1'b0;
    logic [63:0] m_if = '0, m_dm = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(bit d, bit wr, logic [63:0] addr, logic [63:0] wdata,
                                logic [5:0] size, logic [63:0] prd, int delay, bit kill);
        txn_t t;
        t.d = d; t.wr = d & wr; t.addr = addr; t.wdata = d ? wdata : 64'd0;
        t.size = d ? size : 6'd3; t.prdata = prd; t.delay = delay; t.kill = ~d & kill;
        return t;
    endfunction

    function automatic txn_t rnd(bit d, bit kill);
        int dl = ($urandom_range(0, 12) == 0 && !kill) ? NO_RESP : int'($urandom_range(0, 7));
        return mk(d, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  6'($urandom_range(0, 3)), {$urandom, $urandom}, dl, kill);
    endfunction

    // reference model: transactions are booked in the order the port must serve them
    function automatic void book(input txn_t t);
        exp_t e;
        port_q.push_back(t);
        last_d = t.d;
        e.d = t.d;
        e.err = (t.delay == NO_RESP);
        if (t.d) begin
            if (e.err) m_dm = '0;
            else if (!t.wr) m_dm = t.prdata;
            e.rdata = m_dm;
            done_q.push_back(e);
        end else if (!t.kill) begin
            m_if = e.err ? 64'd0 : t.prdata;
            e.rdata = m_if;
            done_q.push_back(e);
        end
    endfunction

    task automatic req_d(input txn_t t);
        int n = 0;
        dm_wr_en = t.wr; dm_addr = t.addr; dm_wdata = t.wdata; dm_size = t.size; dm_req = 1'b1;
        do begin @(negedge clk); n++; end while (!dm_done && n < 200);
        chk("dm_done_seen", dm_done, 1);
        dm_req = 1'b0; dm_addr = {$urandom, $urandom}; dm_wdata = {$urandom, $urandom};
    endtask

    task automatic req_i(input txn_t t);
        int n = 0;
        if_addr = t.addr; if_req = 1'b1;
        if (t.kill) begin
            do begin @(negedge clk); n++; end while (!port_req && n < 200);
            chk("kill_port_req", port_req, 1);
            if_flush = 1'b1;
            @(negedge clk);
            if_flush = 1'b0; if_req = 1'b0;
        end else begin
            do begin @(negedge clk); n++; end while (!if_done && n < 200);
            chk("if_done_seen", if_done, 1);
            if_req = 1'b0;
        end
        if_addr = {$urandom, $urandom};
    endtask

    task automatic settle();
        int n = 0;
        while ((done_q.size() != 0 || port_q.size() != 0 || port_req) && n < 200) begin
            @(negedge clk); n++;
        end
        repeat (3) @(negedge clk);
        chk("queues_drained", 64'(done_q.size() + port_q.size()), 0);
    endtask

    task automatic run_one(input txn_t t);
        book(t);
        if (t.d) req_d(t); else req_i(t);
        settle();
        if (t.kill) chk("kill_if_rdata", if_rdata, m_if);
    endtask

    task automatic run_pair(input txn_t td, input txn_t ti);
        if (last_d) begin book(ti); book(td); end
        else begin book(td); book(ti); end
        fork
            req_d(td);
            req_i(ti);
        join
        settle();
    endtask

    // cache responder: serves each port transaction with the booked latency and data
    initial begin
        txn_t t;
        int cnt;
        forever begin
            @(negedge clk);
            if (resp_en && port_req) begin
                if (port_q.size() == 0) begin
                    chk("port_req_unbooked", port_req, 0);
                    cnt = 0;
                    while (port_req && cnt < 50) begin @(negedge clk); cnt++; end
                end else begin
                    t = port_q.pop_front();
                    chk("port_addr", port_addr, t.addr);
                    chk("port_wr_en", port_wr_en, t.wr);
                    chk("port_wdata", port_wdata, t.wdata);
                    chk("port_size", port_size, t.size);
                    if (t.delay == NO_RESP) begin
                        cnt = 1;
                        while (port_req && cnt < 50) begin
                            @(negedge clk);
                            if (port_req) cnt++;
                        end
                        chk("timeout_busy_cycles", cnt, TO);
                    end else begin
                        repeat (t.delay) @(negedge clk);
                        chk("port_addr_held", port_addr, t.addr);
                        port_done = 1'b1; port_rdata = t.prdata;
                        @(negedge clk);
                        port_done = 1'b0; port_rdata = {$urandom, $urandom};
                        chk("port_req_dropped", port_req, 0);
                    end
                end
            end
        end
    end

    // monitor: every done pulse is matched against the next expected completion
    always @(negedge clk) begin
        exp_t e;
        if (if_done || dm_done) begin
            if (if_done && dm_done) chk("done_exclusive", {if_done, dm_done}, 2'b01);
            if (done_q.size() == 0) begin
                chk("done_unexpected", {if_done, dm_done}, 0);
            end else begin
                e = done_q.pop_front();
                chk("done_who", dm_done, e.d);
                chk(e.d ? "dm_rdata" : "if_rdata", e.d ? dm_rdata : if_rdata, e.rdata);
                chk("arb_err", arb_err, e.err);
            end
        end else if (arb_err) begin
            chk("arb_err_alone", arb_err, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        txn_t td[3], ti[3], t;
        int kind;
        repeat (3) @(negedge clk);
        chk("rst_port_req", port_req, 0);
        chk("rst_outputs", {if_done, dm_done, arb_err, port_wr_en}, 0);
        chk("rst_port_addr", port_addr, 0);
        chk("rst_rdata", if_rdata | dm_rdata, 0);

        // both requesters present from reset: D, I, D, I, D, I
        for (int k = 0; k < 3; k++) begin
            td[k] = mk(1, 0, 64'h100 + 64'(k), 0, 6'd1, 64'hD0 + 64'(k), k + 1, 0);
            ti[k] = mk(0, 0, 64'h200 + 64'(k), 0, 6'd3, 64'hE0 + 64'(k), k, 0);
            book(td[k]);
            book(ti[k]);
        end
        rst_n = 1'b1;
        fork
            for (int k = 0; k < 3; k++) begin req_d(td[k]); @(negedge clk); end
            for (int k = 0; k < 3; k++) begin req_i(ti[k]); @(negedge clk); end
        join
        settle();

        run_one(mk(1, 0, 64'h1000, 0, 6'd2, 64'hDEAD, 3, 0));
        run_one(mk(1, 1, 64'h20, 64'h55, 6'd3, 64'h1234, 2, 0));
        run_one(mk(0, 0, 64'h300, 0, 6'd3, 64'hBEEF, 2, 1));

        // reset in the middle of a data load
        resp_en = 1'b0;
        dm_wr_en = 1'b0; dm_addr = 64'h4440; dm_size = 6'd3; dm_req = 1'b1;
        kind = 0;
        do begin @(negedge clk); kind++; end while (!port_req && kind < 50);
        chk("rstmid_busy", port_req, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_port_req", port_req, 0);
        chk("rstmid_port_addr", port_addr, 0);
        chk("rstmid_dm_rdata", dm_rdata, 0);
        chk("rstmid_flags", {if_done, dm_done, arb_err, port_wr_en}, 0);
        dm_req = 1'b0;
        last_d = 1'b0; m_if = '0; m_dm = '0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) begin port_done = 1'b1; port_rdata = 64'h7777; end
        @(negedge clk) port_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstmid_idle", {port_req, dm_rdata != 0}, 0);
        resp_en = 1'b1;

        run_one(mk(1, 0, 64'h2000, 0, 6'd3, 64'hCAFE, NO_RESP, 0));
        run_one(mk(0, 0, 64'h2100, 0, 6'd3, 64'hF00D, 7, 0));

        repeat (60) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: run_one(rnd(1, 0));
                1: run_one(rnd(0, 0));
                2: run_pair(rnd(1, 0), rnd(0, 0));
                default: run_one(rnd(0, 1));
            endcase
        end
        chk("final_done_q", 64'(done_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
